// File: rtl/rst_seq_pkg.sv
// Shared definitions for the platform clock/reset blocks: sequencer state
// encoding, relock counter width and parameter range checks.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int RELOCK_W = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

  // Legal parameter ranges; the timeout must leave room for a full filter run.
  function automatic bit params_ok(input int n_ch, input int lock_filt,
                                   input int step, input int lock_timeout,
                                   input int pll_rst_len);
    return (n_ch >= 1) && (lock_filt >= 1) && (step >= 1) &&
           (pll_rst_len >= 1) && (lock_timeout >= lock_filt + 2);
  endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchroniser for asynchronous status inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  // Two register stages to let the first one settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: pulses the PLL reset, filters lock, then releases the
// channel resets one by one at fixed spacing; re-asserts all on lock loss.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int LOCK_FILT    = 16,
  parameter int STEP         = 8,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int PLL_RST_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_ok,
  output logic                pll_rst,
  output logic [N_CH-1:0]     rst_out,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int PLL_W  = $clog2(PLL_RST_LEN + 1);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int STEP_W = $clog2(STEP + 1);
  localparam int IDX_W  = $clog2(N_CH + 1);

  if (!params_ok(N_CH, LOCK_FILT, STEP, LOCK_TIMEOUT, PLL_RST_LEN)) begin : g_param_error
    $error("rst_seq: parameter out of range");
  end

  state_t              state_reg, state_next;
  logic [PLL_W-1:0]    pll_cnt_reg, pll_cnt_next;
  logic [FILT_W-1:0]   filt_reg, filt_next;
  logic [TO_W-1:0]     to_reg, to_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [N_CH-1:0]     rst_out_reg, rst_out_next;
  logic [RELOCK_W-1:0] relock_reg, relock_next;
  logic                pll_rst_reg;
  logic                ready_reg;
  logic                lock_s;
  logic [N_CH-1:0]     rel_mask;

  sync2 #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_ok),
    .q   (lock_s)
  );

  // One-hot mask of the channel currently addressed by the index counter.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
    assign rel_mask[gi] = (idx_reg == IDX_W'(gi));
  end

  // Next-state, counter and channel logic; counters default to cleared.
  always_comb begin
    state_next   = state_reg;
    pll_cnt_next = '0;
    filt_next    = '0;
    to_next      = '0;
    step_next    = '0;
    idx_next     = '0;
    rst_out_next = rst_out_reg;
    relock_next  = relock_reg;
    case (state_reg)
      PLL_RST: begin
        rst_out_next = '1;
        if (pll_cnt_reg == PLL_W'(PLL_RST_LEN - 1)) begin
          state_next = WAIT_LOCK;
        end else begin
          pll_cnt_next = pll_cnt_reg + PLL_W'(1);
        end
      end
      WAIT_LOCK: begin
        rst_out_next = '1;
        // Reaching the filter count wins over a coincident timeout.
        if (lock_s && (filt_reg == FILT_W'(LOCK_FILT - 1))) begin
          state_next = RELEASE;
        end else if (to_reg == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_next = PLL_RST;
        end else begin
          filt_next = lock_s ? (filt_reg + FILT_W'(1)) : '0;
          to_next   = to_reg + TO_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_next   = WAIT_LOCK;
          rst_out_next = '1;
          if (relock_reg != RELOCK_MAX) relock_next = relock_reg + RELOCK_W'(1);
        end else begin
          if (step_reg == '0) rst_out_next = rst_out_reg & ~rel_mask;
          if (step_reg == STEP_W'(STEP - 1)) begin
            step_next = '0;
            idx_next  = (idx_reg == IDX_W'(N_CH - 1)) ? idx_reg : idx_reg + IDX_W'(1);
          end else begin
            step_next = step_reg + STEP_W'(1);
            idx_next  = idx_reg;
          end
          // Move on only once the last channel is already low.
          if (!rst_out_reg[N_CH-1]) state_next = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next   = WAIT_LOCK;
          rst_out_next = '1;
          if (relock_reg != RELOCK_MAX) relock_next = relock_reg + RELOCK_W'(1);
        end
      end
      default: begin
        state_next   = PLL_RST;
        rst_out_next = '1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= PLL_RST;
      pll_cnt_reg <= '0;
      filt_reg    <= '0;
      to_reg      <= '0;
      step_reg    <= '0;
      idx_reg     <= '0;
      rst_out_reg <= '1;
      relock_reg  <= '0;
      pll_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pll_cnt_reg <= pll_cnt_next;
      filt_reg    <= filt_next;
      to_reg      <= to_next;
      step_reg    <= step_next;
      idx_reg     <= idx_next;
      rst_out_reg <= rst_out_next;
      relock_reg  <= relock_next;
      pll_rst_reg <= (state_next == PLL_RST);
      ready_reg   <= (state_next == RUN);
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign rst_out    = rst_out_reg;
  assign ready      = ready_reg;
  assign relock_cnt = relock_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with N_CH=3, LOCK_FILT=4, STEP=2,
// LOCK_TIMEOUT=50, PLL_RST_LEN=3. cyc counts cycles since rst release.
module tb_rst_seq;

  logic       clk;
  logic       rst;
  logic       clk_ok;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic [7:0] relock_cnt;

  int cyc;
  int checks;
  int errors;

  rst_seq #(
    .N_CH         (3),
    .LOCK_FILT    (4),
    .STEP         (2),
    .LOCK_TIMEOUT (50),
    .PLL_RST_LEN  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_ok     (clk_ok),
    .pll_rst    (pll_rst),
    .rst_out    (rst_out),
    .ready      (ready),
    .relock_cnt (relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_ok = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Clean start from cycle 0 with clk_ok high from cycle 10.
  task automatic clean_start(input string p);
    check({p, "_rst_pll"}, 32'(pll_rst), 32'd1);
    check({p, "_rst_out"}, 32'(rst_out), 32'h7);
    check({p, "_rst_ready"}, 32'(ready), 32'd0);
    check({p, "_rst_relock"}, 32'(relock_cnt), 32'd0);
    goto(2);  check({p, "_pll_c2"}, 32'(pll_rst), 32'd1);
    goto(3);  check({p, "_pll_c3"}, 32'(pll_rst), 32'd0);
    goto(10); clk_ok = 1'b1;
    goto(16); check({p, "_out_c16"}, 32'(rst_out), 32'h7);
    goto(17); check({p, "_out_c17"}, 32'(rst_out), 32'h6);
    goto(18); check({p, "_out_c18"}, 32'(rst_out), 32'h6);
    goto(19); check({p, "_out_c19"}, 32'(rst_out), 32'h4);
    goto(21); check({p, "_out_c21"}, 32'(rst_out), 32'h0);
              check({p, "_ready_c21"}, 32'(ready), 32'd0);
    goto(22); check({p, "_ready_c22"}, 32'(ready), 32'd1);
              check({p, "_pll_c22"}, 32'(pll_rst), 32'd0);
  endtask

  initial begin
    int a;
    checks = 0;
    errors = 0;
    cyc = 0;

    // Clean start, then a one-cycle lock loss in RUN.
    do_reset();
    clean_start("clean");
    goto(30); clk_ok = 1'b0;
    goto(31); clk_ok = 1'b1;
    goto(32); check("run_out_c32", 32'(rst_out), 32'h0);
    goto(33); check("loss_out_c33", 32'(rst_out), 32'h7);
              check("loss_ready_c33", 32'(ready), 32'd0);
              check("loss_relock_c33", 32'(relock_cnt), 32'd1);
              check("loss_pll_c33", 32'(pll_rst), 32'd0);
    goto(37); check("relock_out_c37", 32'(rst_out), 32'h7);
    goto(38); check("relock_out_c38", 32'(rst_out), 32'h6);
    goto(40); check("relock_out_c40", 32'(rst_out), 32'h4);
    goto(42); check("relock_out_c42", 32'(rst_out), 32'h0);
              check("relock_ready_c42", 32'(ready), 32'd0);
    goto(43); check("relock_ready_c43", 32'(ready), 32'd1);
              check("relock_pll_c43", 32'(pll_rst), 32'd0);
              check("relock_cnt_c43", 32'(relock_cnt), 32'd1);

    // Lock never arrives: PLL reset re-pulsed on timeout.
    do_reset();
    goto(52);  check("nolock_pll_c52", 32'(pll_rst), 32'd0);
    goto(53);  check("nolock_pll_c53", 32'(pll_rst), 32'd1);
    goto(55);  check("nolock_pll_c55", 32'(pll_rst), 32'd1);
    goto(56);  check("nolock_pll_c56", 32'(pll_rst), 32'd0);
               check("nolock_out_c56", 32'(rst_out), 32'h7);
    goto(105); check("nolock_pll_c105", 32'(pll_rst), 32'd0);
    goto(106); check("nolock_pll_c106", 32'(pll_rst), 32'd1);
    goto(108); check("nolock_pll_c108", 32'(pll_rst), 32'd1);
    goto(109); check("nolock_pll_c109", 32'(pll_rst), 32'd0);
               check("nolock_out_c109", 32'(rst_out), 32'h7);
               check("nolock_ready_c109", 32'(ready), 32'd0);

    // One-cycle glitch during filtering restarts the filter.
    do_reset();
    goto(10); clk_ok = 1'b1;
    goto(13); clk_ok = 1'b0;
    goto(14); clk_ok = 1'b1;
    goto(17); check("glitch_out_c17", 32'(rst_out), 32'h7);
    goto(20); check("glitch_out_c20", 32'(rst_out), 32'h7);
    goto(21); check("glitch_out_c21", 32'(rst_out), 32'h6);
    goto(25); check("glitch_ready_c25", 32'(ready), 32'd0);
    goto(26); check("glitch_ready_c26", 32'(ready), 32'd1);

    // Lock loss in the middle of RELEASE.
    do_reset();
    goto(10); clk_ok = 1'b1;
    goto(17); check("midrel_out_c17", 32'(rst_out), 32'h6);
              clk_ok = 1'b0;
    goto(18); clk_ok = 1'b1;
    goto(19); check("midrel_out_c19", 32'(rst_out), 32'h4);
    goto(20); check("midrel_out_c20", 32'(rst_out), 32'h7);
              check("midrel_relock_c20", 32'(relock_cnt), 32'd1);
              check("midrel_ready_c20", 32'(ready), 32'd0);
    goto(25); check("midrel_out_c25", 32'(rst_out), 32'h6);

    // 300 lock-loss events: counter saturates at 255.
    do_reset();
    goto(10); clk_ok = 1'b1;
    goto(30);
    for (int i = 1; i <= 300; i++) begin
      a = cyc;
      clk_ok = 1'b0;
      step();
      clk_ok = 1'b1;
      goto(a + 10);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("sat_relock_%0d", i), 32'(relock_cnt), 32'((i > 255) ? 255 : i));
    end
    check("sat_out_release", 32'(rst_out), 32'h4);

    // rst during RELEASE: immediate return to reset values, then full repeat.
    rst = 1'b1;
    clk_ok = 1'b0;
    step();
    check("rstmid_pll", 32'(pll_rst), 32'd1);
    check("rstmid_out", 32'(rst_out), 32'h7);
    check("rstmid_relock", 32'(relock_cnt), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    cyc = 0;
    clean_start("repeat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
